// File: rtl/mem_arb_pkg.sv
// Shared encodings and default sizes for the unified-memory port arbiter.
// Imported by the arbiter top and its round-robin picker.
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MEM_WORDS = 64;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin picker: bit 0 is fetch, bit 1 is data.
// On a tie the requester that did not own the previous access wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_owner,
  output logic [1:0] gnt
);

  // One-hot grant selection
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if (last_owner == OWN_D) begin
          gnt = 2'b01;
        end else begin
          gnt = 2'b10;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store.
// Each access is IDLE (latch winner) then ACCESS (drive memory), response in the next IDLE.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_WORDS  = DEF_MEM_WORDS,
  parameter int ADDR_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              rsp_err,
  output logic              mem_WrEn,
  output logic              mem_RdEn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_WrData,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_r;
  state_e              state_next_s;
  owner_e              last_owner_r;
  owner_e              owner_r;
  owner_e              win_owner_s;
  logic [ADDR_W-1:0]   addr_r;
  logic                we_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   if_rdata_r;
  logic [DATA_W-1:0]   d_rdata_r;
  logic                if_rvalid_r;
  logic                d_rvalid_r;
  logic                rsp_err_r;

  logic [1:0]          req_s;
  logic [1:0]          gnt_s;
  logic [ADDR_W-1:0]   idx_s;
  logic                in_range_s;
  logic [DATA_W-1:0]   rsp_data_s;

  assign req_s       = {d_req, if_req};
  assign win_owner_s = gnt_s[1] ? OWN_D : OWN_IF;
  assign idx_s       = addr_r >> ADDR_SHIFT;
  assign in_range_s  = (idx_s < ADDR_W'(MEM_WORDS));
  // Stores and out-of-range accesses return zero data
  assign rsp_data_s  = (in_range_s && !we_r) ? mem_rdata : {DATA_W{1'b0}};

  rr_arb2 u_rr_arb2 (
    .req        (req_s),
    .last_owner (last_owner_r),
    .gnt        (gnt_s)
  );

  // Next-state and memory/grant outputs, all decoded from registered state
  always_comb begin
    state_next_s = state_r;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    mem_WrEn     = 1'b0;
    mem_RdEn     = 1'b0;
    mem_addr     = {ADDR_W{1'b0}};
    mem_WrData   = {DATA_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (|req_s) begin
          state_next_s = ST_ACCESS;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_next_s = ST_IDLE;
        if_gnt       = (owner_r == OWN_IF);
        d_gnt        = (owner_r == OWN_D);
        mem_addr     = idx_s;
        mem_WrData   = wdata_r;
        // Enables drop during reset so an interrupted store never commits
        if (in_range_s && !rst) begin
          mem_WrEn = we_r;
          mem_RdEn = !we_r;
        end else begin
          mem_WrEn = 1'b0;
          mem_RdEn = 1'b0;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register, request latch and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      last_owner_r <= OWN_D;
      owner_r      <= OWN_IF;
      addr_r       <= {ADDR_W{1'b0}};
      we_r         <= 1'b0;
      wdata_r      <= {DATA_W{1'b0}};
      if_rdata_r   <= {DATA_W{1'b0}};
      d_rdata_r    <= {DATA_W{1'b0}};
      if_rvalid_r  <= 1'b0;
      d_rvalid_r   <= 1'b0;
      rsp_err_r    <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      rsp_err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (|req_s) begin
            owner_r      <= win_owner_s;
            last_owner_r <= win_owner_s;
            if (gnt_s[1]) begin
              addr_r  <= d_addr;
              we_r    <= d_we;
              wdata_r <= d_wdata;
            end else begin
              addr_r  <= if_addr;
              we_r    <= 1'b0;
              wdata_r <= {DATA_W{1'b0}};
            end
          end
        end
        ST_ACCESS: begin
          rsp_err_r <= !in_range_s;
          if (owner_r == OWN_D) begin
            d_rvalid_r <= 1'b1;
            d_rdata_r  <= rsp_data_s;
          end else begin
            if_rvalid_r <= 1'b1;
            if_rdata_r  <= rsp_data_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_rvalid = if_rvalid_r;
  assign if_rdata  = if_rdata_r;
  assign d_rvalid  = d_rvalid_r;
  assign d_rdata   = d_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vectors, corner sequences
// and a randomized run against a transaction-schedule reference model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid, rsp_err;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_WrData, mem_rdata;
  logic          mem_WrEn, mem_RdEn;

  logic          s_if_req, s_if_gnt, s_if_rvalid, s_d_req, s_d_we, s_d_gnt, s_d_rvalid, s_rsp_err;
  logic [AW-1:0] s_if_addr, s_d_addr, s_mem_addr;
  logic [DW-1:0] s_if_rdata, s_d_wdata, s_d_rdata, s_mem_WrData, s_mem_rdata;
  logic          s_mem_WrEn, s_mem_RdEn;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW), .ADDR_SHIFT(0)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .rsp_err(rsp_err),
    .mem_WrEn(mem_WrEn), .mem_RdEn(mem_RdEn), .mem_addr(mem_addr), .mem_WrData(mem_WrData),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW), .ADDR_SHIFT(2)) dut_shift (
    .clk(clk), .rst(rst),
    .if_req(s_if_req), .if_addr(s_if_addr), .if_gnt(s_if_gnt), .if_rvalid(s_if_rvalid), .if_rdata(s_if_rdata),
    .d_req(s_d_req), .d_we(s_d_we), .d_addr(s_d_addr), .d_wdata(s_d_wdata), .d_gnt(s_d_gnt),
    .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata), .rsp_err(s_rsp_err),
    .mem_WrEn(s_mem_WrEn), .mem_RdEn(s_mem_RdEn), .mem_addr(s_mem_addr), .mem_WrData(s_mem_WrData),
    .mem_rdata(s_mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h00C8_0693;
    return 32'h1000_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  // Memory stub: combinational read, write on the rising edge, reload on mem_load
  logic [DW-1:0] mem [0:MW-1];
  logic          mem_load;
  assign mem_rdata   = (mem_addr < 32'(MW)) ? mem[mem_addr[5:0]] : 32'hDEAD_BEEF;
  assign s_mem_rdata = (s_mem_addr < 32'(MW)) ? mem[s_mem_addr[5:0]] : 32'hBAD0_BAD0;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < MW; i++) mem[i] <= init_word(i);
    end else if (mem_WrEn && (mem_addr < 32'(MW))) begin
      mem[mem_addr[5:0]] <= mem_WrData;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_load = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    s_if_req = 1'b0; s_if_addr = '0; s_d_req = 1'b0; s_d_we = 1'b0; s_d_addr = '0; s_d_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; mem_load = 1'b0;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_rd;
    bit          exp_wr;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  function automatic vec_t mk(bit is_d, bit we, logic [31:0] addr, logic [31:0] wdata,
                              bit rd, bit wr, logic [31:0] rdata, bit err);
    vec_t v;
    v.is_d = is_d; v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_rd = rd; v.exp_wr = wr; v.exp_rdata = rdata; v.exp_err = err;
    return v;
  endfunction

  task automatic run_vec(input int i, input vec_t v);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
      d_we = 1'b1; d_wdata = 32'hFFFF_FFFF; d_addr = 32'd0;
    end
    @(negedge clk);
    check($sformatf("vec%0d_gnt", i), {if_gnt, d_gnt}, v.is_d ? 64'd1 : 64'd2);
    check($sformatf("vec%0d_rden", i), mem_RdEn, v.exp_rd);
    check($sformatf("vec%0d_wren", i), mem_WrEn, v.exp_wr);
    check($sformatf("vec%0d_maddr", i), mem_addr, v.addr);
    if (v.exp_wr) check($sformatf("vec%0d_wrdata", i), mem_WrData, v.wdata);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check($sformatf("vec%0d_rvalid", i), {if_rvalid, d_rvalid}, v.is_d ? 64'd1 : 64'd2);
    check($sformatf("vec%0d_err", i), rsp_err, v.exp_err);
    check($sformatf("vec%0d_rdata", i), v.is_d ? d_rdata : if_rdata, v.exp_rdata);
    check($sformatf("vec%0d_idle_mem", i), {mem_WrEn, mem_RdEn, if_gnt, d_gnt}, 64'd0);
  endtask

  typedef struct {
    int          gcyc;
    bit          own;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } txn_t;

  vec_t        tbl [8];
  logic [31:0] ref_mem [0:MW-1];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int   ord [4];
    int   n_g;
    int   both;
    txn_t sched [$];
    bit   last_win;
    logic [31:0] e_if_rdata, e_d_rdata;
    bit          rq [2];
    logic [31:0] ra [2];
    bit          rw [2];
    logic [31:0] rwd [2];

    // Reset values
    do_reset();
    check("rst_gnt", {if_gnt, d_gnt}, 64'd0);
    check("rst_rvalid", {if_rvalid, d_rvalid, rsp_err}, 64'd0);
    check("rst_rdata", {if_rdata, d_rdata}, 64'd0);
    check("rst_mem", {mem_WrEn, mem_RdEn, mem_addr, mem_WrData}, 64'd0);

    // Both held: IF, D, IF, D with no overlapping grants
    if_req = 1'b1; if_addr = 32'd1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'd2;
    n_g = 0; both = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (if_gnt && d_gnt) both++;
      if (n_g < 4 && if_gnt) begin ord[n_g] = 0; n_g++; end
      else if (n_g < 4 && d_gnt) begin ord[n_g] = 1; n_g++; end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("tie_overlap", both, 0);
    check("tie_count", n_g, 4);
    for (int i = 0; i < 4; i++) check($sformatf("tie_order%0d", i), ord[i], i % 2);
    @(negedge clk);

    // Single transactions
    tbl[0] = mk(1'b0, 1'b0, 32'd0,     32'd0,        1'b1, 1'b0, 32'h00C8_0693, 1'b0);
    tbl[1] = mk(1'b1, 1'b1, 32'd10,    32'd69,       1'b0, 1'b1, 32'd0,         1'b0);
    tbl[2] = mk(1'b1, 1'b0, 32'd10,    32'd0,        1'b1, 1'b0, 32'd69,        1'b0);
    tbl[3] = mk(1'b1, 1'b0, 32'd64,    32'd0,        1'b0, 1'b0, 32'd0,         1'b1);
    tbl[4] = mk(1'b1, 1'b1, 32'd70,    32'h55,       1'b0, 1'b0, 32'd0,         1'b1);
    tbl[5] = mk(1'b0, 1'b0, 32'd63,    32'd0,        1'b1, 1'b0, init_word(63), 1'b0);
    tbl[6] = mk(1'b1, 1'b0, 32'd63,    32'd0,        1'b1, 1'b0, init_word(63), 1'b0);
    tbl[7] = mk(1'b0, 1'b0, 32'h100,   32'd0,        1'b0, 1'b0, 32'd0,         1'b1);
    for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

    // Reset during a store's ACCESS cycle
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd20; d_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("rstacc_gnt", d_gnt, 1'b1);
    rst = 1'b1;
    #1;
    check("rstacc_wren", {mem_WrEn, mem_RdEn}, 64'd0);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rstacc_mem", mem[20], init_word(20));
    check("rstacc_rvalid", {if_rvalid, d_rvalid, rsp_err}, 64'd0);
    check("rstacc_rdata", {if_rdata, d_rdata}, 64'd0);
    check("rstacc_gnts", {if_gnt, d_gnt, mem_WrEn, mem_RdEn}, 64'd0);
    @(negedge clk);
    check("rstacc_late_rvalid", {if_rvalid, d_rvalid}, 64'd0);

    // Byte-addressed instance
    for (int j = 0; j < 3; j++) begin
      logic [31:0] a;
      logic [31:0] w;
      a = (j == 0) ? 32'h14 : ((j == 1) ? 32'hFC : 32'h100);
      w = a >> 2;
      s_if_req = 1'b1; s_if_addr = a;
      @(negedge clk);
      check($sformatf("shift%0d_gnt", j), s_if_gnt, 1'b1);
      check($sformatf("shift%0d_maddr", j), s_mem_addr, w);
      check($sformatf("shift%0d_rden", j), s_mem_RdEn, (w < 32'(MW)) ? 1'b1 : 1'b0);
      s_if_req = 1'b0;
      @(negedge clk);
      check($sformatf("shift%0d_rvalid", j), s_if_rvalid, 1'b1);
      check($sformatf("shift%0d_err", j), s_rsp_err, (w < 32'(MW)) ? 1'b0 : 1'b1);
      check($sformatf("shift%0d_rdata", j), s_if_rdata, (w < 32'(MW)) ? init_word(int'(w)) : 32'd0);
    end

    // Randomized traffic against a transaction schedule
    do_reset();
    for (int i = 0; i < MW; i++) ref_mem[i] = init_word(i);
    last_win = 1'b1;
    e_if_rdata = '0; e_d_rdata = '0;
    for (int p = 0; p < 2; p++) begin rq[p] = 1'b0; ra[p] = '0; rw[p] = 1'b0; rwd[p] = '0; end
    for (int k = 0; k < 600; k++) begin
      bit          busy, g_if, g_d, v_if, v_d, e_err, e_rd, e_wr;
      logic [31:0] e_ma, e_wd;
      busy = 0; g_if = 0; g_d = 0; v_if = 0; v_d = 0; e_err = 0; e_rd = 0; e_wr = 0;
      e_ma = '0; e_wd = '0;
      foreach (sched[j]) begin
        if (sched[j].gcyc == k) begin
          busy = 1;
          if (sched[j].own) g_d = 1; else g_if = 1;
          e_ma = sched[j].addr;
          e_rd = !sched[j].err && !sched[j].we;
          e_wr = !sched[j].err && sched[j].we;
          e_wd = sched[j].wdata;
        end
        if (sched[j].gcyc + 1 == k) begin
          e_err = sched[j].err;
          if (sched[j].own) begin v_d = 1; e_d_rdata = sched[j].rdata; end
          else begin v_if = 1; e_if_rdata = sched[j].rdata; end
        end
      end
      while (sched.size() > 0 && sched[0].gcyc + 1 < k) void'(sched.pop_front());

      check("rnd_gnt", {if_gnt, d_gnt}, {62'd0, g_if, g_d});
      check("rnd_mem_en", {mem_RdEn, mem_WrEn}, {62'd0, e_rd, e_wr});
      check("rnd_maddr", mem_addr, e_ma);
      if (e_wr) check("rnd_wrdata", mem_WrData, e_wd);
      check("rnd_rsp", {if_rvalid, d_rvalid, rsp_err}, {61'd0, v_if, v_d, e_err});
      check("rnd_if_rdata", if_rdata, e_if_rdata);
      check("rnd_d_rdata", d_rdata, e_d_rdata);

      // Requesters: drop or re-issue after a grant, otherwise hold or start
      for (int p = 0; p < 2; p++) begin
        bit granted;
        granted = (p == 0) ? g_if : g_d;
        if ((granted && ($urandom_range(0, 3) == 0)) || (!granted && !rq[p] && ($urandom_range(0, 2) == 0))) begin
          rq[p] = 1'b1; ra[p] = 32'($urandom_range(0, MW + 3));
          rw[p] = 1'($urandom_range(0, 1)); rwd[p] = $urandom;
        end else if (granted) begin
          rq[p] = 1'b0;
        end
      end
      if_req = rq[0]; if_addr = ra[0];
      d_req = rq[1]; d_addr = ra[1]; d_we = rq[1] ? rw[1] : 1'($urandom_range(0, 1)); d_wdata = rwd[1];

      if (!busy && (rq[0] || rq[1])) begin
        txn_t t;
        bit   win;
        win = (rq[0] && rq[1]) ? !last_win : rq[1];
        last_win = win;
        t.gcyc = k + 1; t.own = win; t.addr = ra[win];
        t.we = win ? rw[1] : 1'b0;
        t.wdata = win ? rwd[1] : 32'd0;
        t.err = (t.addr >= 32'(MW));
        t.rdata = (t.err || t.we) ? 32'd0 : ref_mem[t.addr[5:0]];
        if (!t.err && t.we) ref_mem[t.addr[5:0]] = t.wdata;
        sched.push_back(t);
      end
      @(negedge clk);
    end
    if_req = 1'b0; d_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
